// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n -- N-channel arbiter in front of a single-port main memory.
//
// One channel is granted at a time. Its request is forwarded over the
// mem_enable/mem_ack handshake. Read data and a one-hot acknowledge are
// returned to that channel. Arbitration is fixed priority (lowest index wins)
// or round-robin. An optional cycle timeout aborts a stalled access and
// flags ch_err.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   ch_req/ch_rw        : per-channel request and direction (1 = read)
//   ch_addr/ch_wdata    : per-channel address and write data, slice i = channel i
//   ch_ack              : one-hot acknowledge, held until the four-phase close
//   ch_rdata/ch_err     : shared read data and timeout flag, valid with ch_ack
//   grant_id/busy       : currently granted channel, arbiter not idle
//   mem_*               : memory request side (enable/rw/addr/data, ack/data back)
module mem_arbiter_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_rw,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic                           ch_err,
  output logic [$clog2(NUM_CH)-1:0]      grant_id,
  output logic                           busy,
  output logic                           mem_enable,
  output logic                           mem_rw,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_data_in,
  input  logic                           mem_ack,
  input  logic [DATA_W-1:0]              mem_data_out
);

  localparam int GW    = $clog2(NUM_CH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [GW-1:0]    rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             win_vld;
  logic [GW-1:0]    win_id;
  logic [NUM_CH-1:0] grant_oh;
  logic [GW-1:0]    ptr_next;

  // Scan offsets from highest to lowest so the lowest offset is the last
  // assignment and therefore wins. Offsets are relative to rr_ptr in
  // round-robin mode and to channel 0 in fixed-priority mode.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      logic [GW-1:0] idx;
      idx = (RR_MODE != 0) ? GW'((int'(rr_ptr) + off) % NUM_CH) : GW'(off);
      if (ch_req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign grant_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_id;
  assign ptr_next = (grant_id == GW'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch_ack      <= '0;
      ch_rdata    <= '0;
      ch_err      <= 1'b0;
      grant_id    <= '0;
      mem_enable  <= 1'b0;
      mem_rw      <= 1'b1;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          grant_id    <= win_id;
          mem_rw      <= ch_rw[win_id];
          mem_addr    <= ch_addr[win_id];
          mem_data_in <= ch_rw[win_id] ? '0 : ch_wdata[win_id];
          mem_enable  <= 1'b1;
          cnt         <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          if (mem_ack) begin
            mem_enable <= 1'b0;
            if (mem_rw) ch_rdata <= mem_data_out;
            ch_ack <= grant_oh;
            ch_err <= 1'b0;
            state  <= DONE;
          end else if (TIMEOUT > 0) begin
            // Abort: memory must tolerate enable dropping without an ack.
            if (cnt == CNT_MAX) begin
              mem_enable <= 1'b0;
              ch_ack     <= grant_oh;
              ch_err     <= 1'b1;
              state      <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: if (!ch_req[grant_id] && !mem_ack) begin
          ch_ack <= '0;
          ch_err <= 1'b0;
          rr_ptr <= ptr_next;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
